// File: rtl/move_gen.sv
// Successor-board generator for the 6-puzzle: finds the space tile with CHECKk ops,
// then issues each legal, non-undoing move and hands the ALU result downstream.
module move_gen #(
  parameter logic [2:0] SPACE_CODE = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [25:0] board,
  input  logic        prev_valid,
  input  logic [1:0]  prev_dir,
  output logic [6:0]  alu_op,
  output logic [25:0] alu_in0,
  output logic [25:0] alu_in1,
  input  logic [25:0] alu_out,
  input  logic        alu_zf,
  output logic        child_valid,
  input  logic        child_ready,
  output logic [25:0] child_data,
  output logic [1:0]  child_dir,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  child_cnt
);

  // Opcode encodings shared with the ALU; CHECKk = OpCheckBase + k.
  localparam logic [6:0] OpLoad      = 7'h01;
  localparam logic [6:0] OpCheckBase = 7'h10;
  localparam logic [6:0] OpRight     = 7'h20;

  typedef enum logic [2:0] {StIdle, StScan, StGen, StOut, StFin} state_e;

  state_e      state_q, state_d;
  logic [25:0] parent_q;
  logic        prev_valid_q;
  logic [1:0]  prev_dir_q;
  logic [2:0]  k_q;
  logic [2:0]  p_q;
  logic [2:0]  d_q;
  logic        child_valid_q;
  logic [25:0] child_data_q;
  logic [1:0]  child_dir_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [2:0]  cnt_q;
  logic        gen_found;
  logic [1:0]  gen_dir;

  // Direction order is R=0, L=1, U=2, D=3; positions 1..3 are the top row.
  function automatic logic dir_legal(input logic [2:0] p, input logic [1:0] dir);
    case (dir)
      2'd0:    return (p == 3'd1) || (p == 3'd2) || (p == 3'd4) || (p == 3'd5);
      2'd1:    return (p == 3'd2) || (p == 3'd3) || (p == 3'd5) || (p == 3'd6);
      2'd2:    return (p >= 3'd4) && (p <= 3'd6);
      default: return (p >= 3'd1) && (p <= 3'd3);
    endcase
  endfunction

  // Lowest direction >= d that is legal and does not undo the parent's move.
  always_comb begin
    gen_found = 1'b0;
    gen_dir   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= d_q) && dir_legal(p_q, 2'(i)) &&
          !(prev_valid_q && (2'(i) == (prev_dir_q ^ 2'b01)))) begin
        gen_found = 1'b1;
        gen_dir   = 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StScan;
      StScan: begin
        if (alu_zf)            state_d = StGen;
        else if (k_q == 3'd6)  state_d = StFin;
      end
      StGen:  state_d = gen_found ? StOut : StFin;
      StOut:  if (child_ready) state_d = StGen;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_op  = OpLoad;
    alu_in1 = 26'd0;
    case (state_q)
      StScan: begin
        alu_op  = OpCheckBase + {4'd0, k_q};
        alu_in1 = {23'd0, SPACE_CODE};
      end
      StGen: if (gen_found) alu_op = OpRight + {5'd0, gen_dir};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      parent_q      <= 26'd0;
      prev_valid_q  <= 1'b0;
      prev_dir_q    <= 2'd0;
      k_q           <= 3'd1;
      p_q           <= 3'd0;
      d_q           <= 3'd0;
      child_valid_q <= 1'b0;
      child_data_q  <= 26'd0;
      child_dir_q   <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= 3'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: if (start) begin
          parent_q     <= board;
          prev_valid_q <= prev_valid;
          prev_dir_q   <= prev_dir;
          cnt_q        <= 3'd0;
          err_q        <= 1'b0;
          busy_q       <= 1'b1;
          k_q          <= 3'd1;
        end
        StScan: begin
          if (alu_zf) begin
            p_q <= k_q;
            d_q <= 3'd0;
          end else if (k_q == 3'd6) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        StGen: begin
          if (gen_found) begin
            child_data_q  <= alu_out;
            child_dir_q   <= gen_dir;
            child_valid_q <= 1'b1;
          end else begin
            done_q <= 1'b1;
          end
        end
        StOut: if (child_ready) begin
          child_valid_q <= 1'b0;
          cnt_q         <= cnt_q + 3'd1;
          d_q           <= {1'b0, child_dir_q} + 3'd1;
        end
        StFin: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign alu_in0     = parent_q;
  assign child_valid = child_valid_q;
  assign child_data  = child_data_q;
  assign child_dir   = child_dir_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign child_cnt   = cnt_q;

endmodule

// File: tb/tb_move_gen.sv
// Bench for move_gen: behavioural ALU plus a board-level model of the expected
// children, checked every cycle by one monitor process.
module tb_move_gen;

  localparam logic [6:0] OpLoad = 7'h01;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [25:0] board;
  logic        prev_valid;
  logic [1:0]  prev_dir;
  logic [6:0]  alu_op;
  logic [25:0] alu_in0;
  logic [25:0] alu_in1;
  logic [25:0] alu_out;
  logic        alu_zf;
  logic        child_valid;
  logic        child_ready;
  logic [25:0] child_data;
  logic [1:0]  child_dir;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  child_cnt;

  always #5 clk = ~clk;

  move_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .board      (board),
    .prev_valid (prev_valid),
    .prev_dir   (prev_dir),
    .alu_op     (alu_op),
    .alu_in0    (alu_in0),
    .alu_in1    (alu_in1),
    .alu_out    (alu_out),
    .alu_zf     (alu_zf),
    .child_valid(child_valid),
    .child_ready(child_ready),
    .child_data (child_data),
    .child_dir  (child_dir),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .child_cnt  (child_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] tile(input logic [25:0] b, input int pos);
    return b[(6 - pos) * 3 +: 3];
  endfunction

  // Move the space one step in dir (0=R,1=L,2=U,3=D) on the 2x3 grid.
  function automatic logic [25:0] apply_move(input logic [25:0] b, input int dir, output bit ok);
    int p, q, col, row;
    logic [25:0] r;
    p = 0;
    q = 0;
    ok = 1'b0;
    r = b;
    for (int i = 1; i <= 6; i++) if (p == 0 && tile(b, i) == 3'd0) p = i;
    if (p != 0) begin
      col = (p - 1) % 3;
      row = (p - 1) / 3;
      case (dir)
        0:       begin ok = (col < 2);  q = p + 1; end
        1:       begin ok = (col > 0);  q = p - 1; end
        2:       begin ok = (row == 1); q = p - 3; end
        default: begin ok = (row == 0); q = p + 3; end
      endcase
      if (ok) begin
        r[(6 - p) * 3 +: 3] = tile(b, q);
        r[(6 - q) * 3 +: 3] = 3'd0;
      end
    end
    return r;
  endfunction

  // Behavioural ALU: CHECKk compares position k with operand 1, moves swap.
  bit alu_ok;
  always_comb begin
    alu_out = alu_in0;
    alu_zf  = 1'b0;
    alu_ok  = 1'b0;
    if (alu_op >= 7'h11 && alu_op <= 7'h16)
      alu_zf = (tile(alu_in0, int'(alu_op) - 16) == alu_in1[2:0]);
    else if (alu_op >= 7'h20 && alu_op <= 7'h23)
      alu_out = apply_move(alu_in0, int'(alu_op) - 32, alu_ok);
  end

  typedef struct packed {
    logic [25:0] data;
    logic [1:0]  dir;
  } child_t;

  child_t      exp_q[$];
  logic        exp_err;
  int          exp_cnt;
  int          exp_pos;
  logic [25:0] exp_parent;
  bit          run_active = 1'b0;
  int          got_cnt;
  logic        prev_v, prev_r;
  logic [25:0] prev_d;
  logic [1:0]  prev_dr;

  task automatic build_expected(input logic [25:0] b, input bit pv, input int pd);
    bit ok;
    logic [25:0] nb;
    exp_q.delete();
    exp_pos = 0;
    for (int i = 1; i <= 6; i++) if (exp_pos == 0 && tile(b, i) == 3'd0) exp_pos = i;
    exp_err = (exp_pos == 0);
    for (int d = 0; d < 4; d++) begin
      if (!(pv && d == (pd ^ 1))) begin
        nb = apply_move(b, d, ok);
        if (ok) exp_q.push_back({nb, 2'(d)});
      end
    end
    exp_cnt    = exp_q.size();
    exp_parent = b;
  endtask

  always @(negedge clk) begin
    if (run_active) begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(child_valid), 32'd1);
        chk("hold_data", 32'(child_data), 32'(prev_d));
        chk("hold_dir", 32'(child_dir), 32'(prev_dr));
      end
      if (child_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_child", 32'(child_valid), 32'd0);
        end else begin
          chk("child_data", 32'(child_data), 32'(exp_q[0].data));
          chk("child_dir", 32'(child_dir), 32'(exp_q[0].dir));
          if (child_ready) begin
            void'(exp_q.pop_front());
            got_cnt++;
          end
        end
      end
      if (busy) chk("alu_in0", 32'(alu_in0), 32'(exp_parent));
      else      chk("alu_op_idle", 32'(alu_op), 32'(OpLoad));
      if (done) begin
        chk("err", 32'(err), 32'(exp_err));
        chk("child_cnt", 32'(child_cnt), 32'(exp_cnt));
        chk("children_left", 32'(exp_q.size()), 32'd0);
      end
      prev_v  = child_valid;
      prev_r  = child_ready;
      prev_d  = child_data;
      prev_dr = child_dir;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_child_valid"}, 32'(child_valid), 32'd0);
    chk({tag, "_child_data"}, 32'(child_data), 32'd0);
    chk({tag, "_child_dir"}, 32'(child_dir), 32'd0);
    chk({tag, "_child_cnt"}, 32'(child_cnt), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'(OpLoad));
    chk({tag, "_alu_in0"}, 32'(alu_in0), 32'd0);
    chk({tag, "_alu_in1"}, 32'(alu_in1), 32'd0);
  endtask

  // One full run; stall = cycles ready is held low on the second child.
  task automatic run(input logic [25:0] b, input bit pv, input int pd, input int stall,
                     input bit junk);
    int cyc, first_v, done_c, stall_left, exp_done;
    build_expected(b, pv, pd);
    got_cnt = 0;
    prev_v  = 1'b0;
    run_active = 1'b1;
    @(posedge clk); #1;
    board = b; prev_valid = pv; prev_dir = 2'(pd); start = 1'b1; child_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; board = 26'd0;
    cyc = 1; first_v = -1; done_c = -1; stall_left = stall;
    while (done_c < 0 && cyc < 300) begin
      if (done) begin
        done_c = cyc;
        if (junk) begin start = 1'b1; board = 26'h3FFFFFF; end
      end else if (junk && (cyc == 2 || cyc == 3)) begin
        start = 1'b1; board = 26'h3FFFFFF;
      end else begin
        start = 1'b0;
      end
      if (child_valid && got_cnt == 1 && stall_left > 0) begin
        child_ready = 1'b0;
        stall_left--;
      end else begin
        child_ready = 1'b1;
      end
      if (child_valid && first_v < 0) first_v = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; board = 26'd0;
    chk("done_seen", 32'(done_c >= 0), 32'd1);
    chk("first_child_cycle", 32'(first_v), exp_cnt > 0 ? 32'(exp_pos + 2) : 32'hFFFFFFFF);
    exp_done = exp_err ? 7 : exp_pos + 2 * exp_cnt + 2 + stall;
    chk("done_cycle", 32'(done_c), 32'(exp_done));
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("accepted_cnt", 32'(got_cnt), 32'(exp_cnt));
    run_active = 1'b0;
  endtask

  localparam logic [25:0] BoardP1   = 26'h29414E5;
  localparam logic [25:0] BoardP5   = {8'h5A, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5};
  localparam logic [25:0] BoardNone = {8'h00, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  localparam logic [25:0] BoardP6   = {8'hC3, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; board = 26'd0; prev_valid = 1'b0; prev_dir = 2'd0; child_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Pin the model to hand-computed children.
    build_expected(BoardP1, 1'b0, 0);
    chk("pin_p1_cnt", 32'(exp_q.size()), 32'd2);
    if (exp_q.size() == 2) begin
      chk("pin_p1_r", 32'(exp_q[0].data), 32'h29484E5);
      chk("pin_p1_d", 32'(exp_q[1].data), 32'h2959425);
      chk("pin_p1_d_dir", 32'(exp_q[1].dir), 32'd3);
    end
    build_expected(BoardP5, 1'b0, 0);
    chk("pin_p5_cnt", 32'(exp_q.size()), 32'd3);
    if (exp_q.size() == 3) chk("pin_p5_r", 32'(exp_q[0].data), 32'h168A728);

    run(BoardP1, 1'b0, 0, 0, 1'b0);
    run(BoardP1, 1'b1, 1, 0, 1'b0);
    run(BoardP5, 1'b0, 0, 0, 1'b0);
    run(BoardP5, 1'b0, 0, 5, 1'b0);
    run(BoardNone, 1'b0, 0, 0, 1'b0);

    // Reset while the first child is held in OUT.
    build_expected(BoardP5, 1'b0, 0);
    got_cnt = 0; prev_v = 1'b0; run_active = 1'b1;
    @(posedge clk); #1;
    board = BoardP5; prev_valid = 1'b0; prev_dir = 2'd0; start = 1'b1; child_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !child_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("reset_setup_valid", 32'(child_valid), 32'd1);
    @(posedge clk); #3;
    run_active = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    child_ready = 1'b1;

    run(BoardP6, 1'b1, 0, 0, 1'b1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
